// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module  : cacheline_adapter
// Brief   : Splits cache-line read/write requests into BEATS-beat memory
//           bursts and returns a one-cycle completion pulse to the cache.
// Rev     : 1.0  initial release
// ============================================================================
module cacheline_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   line_read,
    input  logic                   line_write,
    input  logic [31:0]            line_address,
    input  logic [LINE_WIDTH-1:0]  line_wdata,
    output logic [LINE_WIDTH-1:0]  line_rdata,
    output logic                   line_resp,
    output logic                   burst_read,
    output logic                   burst_write,
    output logic [31:0]            burst_address,
    output logic [BURST_WIDTH-1:0] burst_wdata,
    input  logic [BURST_WIDTH-1:0] burst_rdata,
    input  logic                   burst_resp
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = $clog2(BEATS);

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS - 1);
    localparam logic [31:0]      c_addr_mask = ~((32'd1 << $clog2(LINE_WIDTH / 8)) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [LINE_WIDTH-1:0] r_wbuf;

    // The write line is shifted down one beat per accepted beat, so the
    // current beat always sits in the low slice.
    assign burst_wdata = r_wbuf[BURST_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_wbuf        <= '0;
            line_rdata    <= '0;
            line_resp     <= 1'b0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_address <= '0;
        end else begin
            line_resp <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (line_write) begin
                        burst_address <= line_address & c_addr_mask;
                        r_wbuf        <= line_wdata;
                        r_cnt         <= '0;
                        burst_write   <= 1'b1;
                        r_state       <= ST_WRITE;
                    end else if (line_read) begin
                        burst_address <= line_address & c_addr_mask;
                        r_cnt         <= '0;
                        burst_read    <= 1'b1;
                        r_state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (burst_resp) begin
                        line_rdata[int'(r_cnt) * BURST_WIDTH +: BURST_WIDTH] <= burst_rdata;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last_beat) begin
                            burst_read <= 1'b0;
                            line_resp  <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (burst_resp) begin
                        r_wbuf <= r_wbuf >> BURST_WIDTH;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last_beat) begin
                            burst_write <= 1'b0;
                            line_resp   <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cacheline_adapter
// Brief   : Self-checking bench for cacheline_adapter (vector table, corner
//           sequences, randomized transactions against a line-level model).
// Rev     : 1.0  initial release
// ============================================================================
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         line_read, line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata, line_rdata;
    logic         line_resp, burst_read, burst_write, burst_resp;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata, burst_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [255:0] model_rline;

    cacheline_adapter dut (
        .clk(clk), .rst_n(rst_n),
        .line_read(line_read), .line_write(line_write),
        .line_address(line_address), .line_wdata(line_wdata),
        .line_rdata(line_rdata), .line_resp(line_resp),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_address(burst_address), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic         rd;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           waits;
        logic [31:0]  exp_addr;
        int           exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_line_rdata"}, line_rdata, '0);
        chk({tag, "_line_resp"}, line_resp, '0);
        chk({tag, "_burst_dir"}, {burst_read, burst_write}, '0);
        chk({tag, "_burst_address"}, burst_address, '0);
        chk({tag, "_burst_wdata"}, burst_wdata, '0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle following DONE, so the next call issues back-to-back.
    task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [255:0] wdata, input logic [255:0] rdata,
                          input int waits, input logic [31:0] exp_addr, input int exp_lat);
        int cyc, beat, wcnt, cur_w, sum_w, lat;
        bit done, is_wr;
        is_wr = wr;
        line_write = wr; line_read = rd; line_address = addr; line_wdata = wdata;
        burst_resp = 1'b0;
        cyc = 0; beat = 0; wcnt = 0; done = 0;
        cur_w = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
        sum_w = cur_w;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            burst_resp = 1'b0;
            // inputs other than the request level must be ignored mid-transaction
            line_address = $urandom;
            for (int k = 0; k < 8; k++) line_wdata[k*32 +: 32] = $urandom;
            if (line_resp) begin
                done = 1;
                line_read = 1'b0; line_write = 1'b0;
            end else if (beat < 4) begin
                chk("burst_dir", {burst_read, burst_write}, is_wr ? 2'b01 : 2'b10);
                chk("burst_address", burst_address, exp_addr);
                if (is_wr) chk("burst_wdata", burst_wdata, wdata[beat*64 +: 64]);
                if (wcnt == cur_w) begin
                    burst_resp  = 1'b1;
                    burst_rdata = rdata[beat*64 +: 64];
                    beat++;
                    wcnt = 0;
                    if (beat < 4) begin
                        cur_w = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
                        sum_w += cur_w;
                    end
                end else begin
                    burst_rdata = $urandom;
                    wcnt++;
                end
            end
        end
        if (!done) begin
            chk("line_resp_timeout", line_resp, 1'b1);
            line_read = 1'b0; line_write = 1'b0;
        end
        lat = (exp_lat < 0) ? (1 + 4 + sum_w) : exp_lat;
        chk("resp_latency", cyc, lat);
        if (!is_wr) model_rline = rdata;
        chk("line_rdata", line_rdata, model_rline);
        @(negedge clk);
        chk("resp_one_cycle", line_resp, 1'b0);
        chk("idle_no_burst", {burst_read, burst_write}, 2'b00);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h0000_1234, '0,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    0, 32'h0000_1220, 5};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_BEEF,
                    {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                     64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD},
                    '0, 2, 32'h0000_BEE0, 13};
        vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, '0,
                    {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                     64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001},
                    1, 32'hFFFF_FFE0, 9};
        vecs[3] = '{1'b1, 1'b0, 32'h8000_0010,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
                    '0, 0, 32'h8000_0000, 5};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0040, '0,
                    {64'h9999_9999_0000_0000, 64'h8888_8888_0000_0000,
                     64'h7777_7777_0000_0000, 64'h6666_6666_0000_0000},
                    0, 32'h0000_0040, 5};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_011F,
                    {64'h1234_0000_0000_0003, 64'h1234_0000_0000_0002,
                     64'h1234_0000_0000_0001, 64'h1234_0000_0000_0000},
                    '0, 3, 32'h0000_0100, 17};

        // Reset asserted from time zero with a read already pending.
        rst_n = 1'b0; line_read = 1'b1; line_write = 1'b0;
        line_address = 32'h0000_0040; line_wdata = '0;
        burst_resp = 1'b0; burst_rdata = '0;
        model_rline = '0;
        #1;
        chk_all_zero("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_burst_read", burst_read, 1'b1);
        chk("post_reset_address", burst_address, 32'h0000_0040);
        // Asynchronous reset mid-cycle while a read burst is active.
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset_midcycle");
        line_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            do_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].waits, vecs[i].exp_addr, vecs[i].exp_lat);

        // Reset pulse after two beats of a read aborts it without a response.
        line_read = 1'b1; line_address = 32'h0000_2000;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            burst_resp  = 1'b1;
            burst_rdata = 64'hDEAD_0000_0000_0000 | 64'(b);
        end
        @(negedge clk);
        burst_resp = 1'b0; line_read = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset_abort");
        model_rline = '0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_resp", line_resp, 1'b0);
        do_txn(1'b0, 1'b1, 32'h0000_3000, '0,
               {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
                64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001},
               0, 32'h0000_3000, 5);

        // Stray memory responses while idle must change nothing.
        for (int b = 0; b < 3; b++) begin
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
            @(negedge clk);
            chk("idle_resp_no_burst", {burst_read, burst_write, line_resp}, 3'b000);
            chk("idle_resp_rdata", line_rdata, model_rline);
        end
        burst_resp = 1'b0;
        do_txn(1'b0, 1'b1, 32'h0000_4321, '0,
               {64'hBEEF_0000_0000_0004, 64'hBEEF_0000_0000_0003,
                64'hBEEF_0000_0000_0002, 64'hBEEF_0000_0000_0001},
               0, 32'h0000_4320, 5);

        // Randomized transactions against the line-level model.
        for (int t = 0; t < 40; t++) begin
            logic         rwr, rrd;
            logic [31:0]  raddr;
            logic [255:0] rw, rr;
            rwr = 1'($urandom_range(0, 1));
            rrd = rwr ? 1'($urandom_range(0, 1)) : 1'b1;
            raddr = $urandom;
            for (int k = 0; k < 8; k++) begin
                rw[k*32 +: 32] = $urandom;
                rr[k*32 +: 32] = $urandom;
            end
            do_txn(rwr, rrd, raddr, rw, rr, -1, {raddr[31:5], 5'b0}, -1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
